// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared FSM state type and default word width for the serial receiver
package sipo_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - counts captured bits, flags the bit that completes a word
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic wrap
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign wrap = inc && (count_q == CW'(WIDTH - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in parallel-out receiver with valid/ready hand-off and sticky overrun
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             shift,
    input  logic             abort,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             shift_fire;
    logic             wrap;
    logic             complete;
    logic [WIDTH-1:0] word;

    // abort wins over a simultaneous shift, so the bit on that edge is never captured
    assign shift_fire = shift && !abort;
    assign complete   = shift_fire && wrap;
    assign word       = {sr_q, din};

    sipo_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (shift_fire),
        .clr  (abort),
        .wrap (wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (shift_fire) state_d = RECV;
            RECV:    if (abort || complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (abort) begin
            sr_d = '0;
        end else if (shift_fire) begin
            sr_d = word[WIDTH-2:0];
        end
        // a completing word replaces the held one only if the slot is free or being accepted now
        if (complete && (!valid_q || ready)) begin
            data_d  = word;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (complete && valid_q && !ready) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = (state_q == RECV);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - scoreboard bench for sipo_rx: directed scenarios plus randomized traffic
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         shift = 1'b0;
    logic         abort = 1'b0;
    logic         ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         overrun;

    sipo_rx #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .shift   (shift),
        .abort   (abort),
        .ready   (ready),
        .clr_ovr (clr_ovr),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit running = 1'b0;

    int exp_q[$];
    int bits_q[$];
    int m_data = 0;
    bit m_valid = 1'b0;
    bit m_ovr = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        bits_q.delete();
        exp_q.delete();
        m_data  = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    // one clock: inputs applied after the falling edge, reference model advanced, then wait past the rising edge
    task automatic cycle(input bit s, input bit d, input bit a, input bit r, input bit c);
        int w;
        bit done;
        bit drop;
        @(negedge clk);
        #1;
        shift = s; din = d; abort = a; ready = r; clr_ovr = c;
        done = 1'b0;
        drop = 1'b0;
        w = 0;
        if (a) begin
            bits_q.delete();
        end else if (s) begin
            bits_q.push_back(int'(d));
            if (bits_q.size() == W) begin
                foreach (bits_q[i]) w = w * 2 + bits_q[i];
                bits_q.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                exp_q.push_back(w);
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                drop  = 1'b1;
                m_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (!drop && c) m_ovr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        shift = 1'b0; abort = 1'b0; ready = 1'b0; clr_ovr = 1'b0; din = 1'b0;
        model_clear();
        #1;
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int w, input bit r_last);
        for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b0, (i == 0) ? r_last : 1'b0, 1'b0);
    endtask

    // continuous state comparison against the model
    always @(negedge clk) begin
        if (running && !rst) begin
            check("st_valid", int'(valid), int'(m_valid));
            check("st_busy", int'(busy), int'(bits_q.size() != 0));
            check("st_overrun", int'(overrun), int'(m_ovr));
            check("st_data", int'(data), m_data);
        end
    end

    // monitor: every accepted word is popped from the scoreboard and compared
    always @(negedge clk) begin
        #2;
        if (running && !rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 1, 0);
            end else begin
                check("sb_word", int'(data), exp_q.pop_front());
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("init_data", int'(data), 0);
        check("init_valid", int'(valid), 0);
        check("init_busy", int'(busy), 0);
        check("init_overrun", int'(overrun), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        running = 1'b1;

        // four back-to-back bits 1,0,1,1
        cycle(1, 1, 0, 0, 0); check("b2b_busy1", int'(busy), 1);
        cycle(1, 0, 0, 0, 0); check("b2b_busy2", int'(busy), 1);
        cycle(1, 1, 0, 0, 0); check("b2b_busy3", int'(busy), 1);
        cycle(1, 1, 0, 0, 0);
        check("b2b_data", int'(data), 'b1011);
        check("b2b_valid", int'(valid), 1);
        check("b2b_busy4", int'(busy), 0);
        cycle(0, 0, 0, 1, 0);
        check("b2b_consumed", int'(valid), 0);

        // same bits with two idle cycles between shifts
        for (int i = 0; i < 4; i++) begin
            cycle(1, (i == 1) ? 1'b0 : 1'b1, 0, 0, 0);
            if (i < 3) begin
                cycle(0, 0, 0, 0, 0);
                cycle(0, 0, 0, 0, 0);
                check("gap_no_valid", int'(valid), 0);
            end
        end
        check("gap_data", int'(data), 'b1011);
        check("gap_valid", int'(valid), 1);
        cycle(0, 0, 0, 1, 0);

        // overrun: second word dropped while first is unaccepted
        send('b1100, 0);
        send('b0011, 0);
        check("ovr_data", int'(data), 'b1100);
        check("ovr_valid", int'(valid), 1);
        check("ovr_flag", int'(overrun), 1);
        cycle(0, 0, 0, 0, 1);
        check("ovr_cleared", int'(overrun), 0);

        // new word completes at the edge the held one is accepted
        send('b0101, 1);
        check("swap_data", int'(data), 'b0101);
        check("swap_valid", int'(valid), 1);
        check("swap_overrun", int'(overrun), 0);
        cycle(0, 0, 0, 1, 0);

        // abort together with a shift discards the partial word and that bit
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check("abort_busy", int'(busy), 0);
        send('b1110, 0);
        check("abort_data", int'(data), 'b1110);
        cycle(0, 0, 0, 1, 0);

        // reset mid-word, then a fresh word
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        do_reset();
        send('b0110, 0);
        check("rst_word_data", int'(data), 'b0110);
        check("rst_word_valid", int'(valid), 1);
        cycle(0, 0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 6, 1'($urandom),
                      $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4,
                      $urandom_range(0, 19) == 0);
            end
        end
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        running = 1'b0;
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
